// File: rtl/fb_reader_pkg.sv
// Shared types and constants for the framebuffer SDRAM reader.
//   state_e         : reader FSM states (IDLE, REQ, PAUSE)
//   WB_CTI_CLASSIC  : Wishbone cycle type identifier for classic cycles
//   WB_SEL_ALL      : all four byte lanes selected
//   WB_BTE_LINEAR   : burst type extension, unused with classic cycles
package fb_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [3:0] WB_SEL_ALL     = 4'hF;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage : fb_reader_pkg

// File: rtl/fb_sdram_reader_if.sv
// Classic Wishbone bus between the framebuffer reader (master) and the
// SDRAM controller (slave).
//   wb_cyc/wb_stb/wb_we/wb_adr/wb_sel/wb_cti/wb_bte : master -> slave
//   wb_dat_sm/wb_ack/wb_err/wb_rty                  : slave  -> master
interface fb_sdram_reader_if #(
  parameter int ADR_WIDTH = 32
);

  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic [ADR_WIDTH-1:0] wb_adr;
  logic [3:0]           wb_sel;
  logic [2:0]           wb_cti;
  logic [1:0]           wb_bte;
  logic [31:0]          wb_dat_sm;
  logic                 wb_ack;
  logic                 wb_err;
  logic                 wb_rty;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_cti, wb_bte,
    input  wb_dat_sm, wb_ack, wb_err, wb_rty
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_cti, wb_bte,
    output wb_dat_sm, wb_ack, wb_err, wb_rty
  );

endinterface : fb_sdram_reader_if

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a level signal entering the sys_clk
// domain. Output follows the input after two rising edges of sys_clk.
//   sys_clk : destination clock
//   sys_rst : asynchronous, active-high reset (both flops to RST_VAL)
//   d_i     : asynchronous level input
//   q_o     : synchronised level output
module sync2 #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: async reset lives in the sensitivity list; flops clear the moment
  // sys_rst rises, without waiting for a clock edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments make this a two-stage shift; with
      // blocking ones sync_q would see d_i in the same edge.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync2

// File: rtl/fb_sdram_reader.sv
// Framebuffer reader: Wishbone master that fetches the frame from SDRAM one
// 32-bit pixel at a time in raster order and pushes each pixel into the
// write side of the CDC pixel FIFO.
//   sys_clk, sys_rst   : system clock, async active-high reset
//   fill_en_async      : fetch enable from the pixel domain (synchronised here)
//   fifo_walmostfull   : FIFO has two or fewer free words
//   fifo_write         : one-cycle FIFO write strobe
//   fifo_wdata         : pixel word written to the FIFO
//   frame_done         : pulses with the write of the last pixel of a frame
//   wb                 : Wishbone master port (classic single reads)
module fb_sdram_reader
  import fb_reader_pkg::*;
#(
  parameter int                   HDISP     = 800,
  parameter int                   VDISP     = 480,
  parameter int                   ADR_WIDTH = 32,
  parameter logic [ADR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              fill_en_async,
  input  logic              fifo_walmostfull,
  output logic              fifo_write,
  output logic [31:0]       fifo_wdata,
  output logic              frame_done,
  fb_sdram_reader_if.master wb
);

  localparam int                NPIX     = HDISP * VDISP;
  localparam int                CNT_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(NPIX - 1);

  state_e           state_q;
  logic [CNT_W-1:0] pix_cnt_q;
  logic [CNT_W-1:0] pix_cnt_d;
  logic             cyc_q;
  logic             fifo_write_q;
  logic [31:0]      fifo_wdata_q;
  logic             frame_done_q;
  logic             fill_en;
  logic             resp_fail;

  sync2 #(.RST_VAL(1'b0)) u_fill_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .d_i     (fill_en_async),
    .q_o     (fill_en)
  );

  // err or rty wins over a simultaneous ack: the beat is discarded and retried.
  assign resp_fail = wb.wb_err | wb.wb_rty;

  // NOTE: every always_comb output gets a value on every path, otherwise a
  // latch is inferred.
  always_comb begin
    pix_cnt_d = pix_cnt_q + 1'b1;
    if (pix_cnt_q == LAST_PIX) begin
      pix_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      cyc_q        <= 1'b0;
      fifo_write_q <= 1'b0;
      fifo_wdata_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only on the
      // edge that accepts data, so they can never stick high.
      fifo_write_q <= 1'b0;
      frame_done_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // A new fill always starts from pixel (0,0).
          pix_cnt_q <= '0;
          if (fill_en) begin
            if (fifo_walmostfull) begin
              state_q <= PAUSE;
            end else begin
              state_q <= REQ;
              cyc_q   <= 1'b1;
            end
          end
        end

        REQ: begin
          if (resp_fail) begin
            // Drop the strobe for one cycle via PAUSE, then retry the same
            // address; pix_cnt_q is untouched.
            cyc_q   <= 1'b0;
            state_q <= fill_en ? PAUSE : IDLE;
          end else if (wb.wb_ack) begin
            fifo_write_q <= 1'b1;
            fifo_wdata_q <= wb.wb_dat_sm;
            frame_done_q <= (pix_cnt_q == LAST_PIX);
            pix_cnt_q    <= pix_cnt_d;
            if (!fill_en) begin
              state_q <= IDLE;
              cyc_q   <= 1'b0;
            end else if (fifo_walmostfull) begin
              state_q <= PAUSE;
              cyc_q   <= 1'b0;
            end
            // Otherwise stay in REQ with the strobe up for the next pixel.
          end
        end

        PAUSE: begin
          if (!fill_en) begin
            state_q <= IDLE;
          end else if (!fifo_walmostfull) begin
            state_q <= REQ;
            cyc_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  // Address follows the pixel counter, which only moves on an accepted beat,
  // so it is stable for the whole of a request.
  assign wb.wb_adr    = BASE_ADDR + (ADR_WIDTH'(pix_cnt_q) << 2);
  assign wb.wb_cyc    = cyc_q;
  assign wb.wb_stb    = cyc_q;
  assign wb.wb_we     = 1'b0;
  assign wb.wb_sel    = WB_SEL_ALL;
  assign wb.wb_cti    = WB_CTI_CLASSIC;
  assign wb.wb_bte    = WB_BTE_LINEAR;

  assign fifo_write   = fifo_write_q;
  assign fifo_wdata   = fifo_wdata_q;
  assign frame_done   = frame_done_q;

endmodule : fb_sdram_reader
